// File: rtl/handshake_constant_seq.sv
`default_nettype none
// ============================================================================
// Module   : handshake_constant_seq
// Purpose  : Emits a cyclic table of compile-time constants, one entry per
//            accepted control token, with an optional one-slot output register.
// Revision : 1.0
// ============================================================================
module handshake_constant_seq #(
    parameter int                                DATA_WIDTH  = 32,
    parameter int                                NUM_CONSTS  = 4,
    parameter logic [NUM_CONSTS*DATA_WIDTH-1:0]  CONST_TABLE = '0,
    parameter int                                BUFFERED    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int c_IDX_W       = (NUM_CONSTS > 1) ? $clog2(NUM_CONSTS) : 1;
    localparam int c_TABLE_DEPTH = 1 << c_IDX_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CONSTS - 1);

    logic [c_IDX_W-1:0]    r_idx;
    logic                  w_ctrl_ready;
    logic                  w_ctrl_fire;
    logic                  w_is_last;
    logic [DATA_WIDTH-1:0] w_entry;
    logic [DATA_WIDTH-1:0] w_table [c_TABLE_DEPTH];

    // Table padded to a power of two so every index value selects a defined entry
    for (genvar gi = 0; gi < c_TABLE_DEPTH; gi++) begin : g_table
        if (gi < NUM_CONSTS) begin : g_entry
            assign w_table[gi] = CONST_TABLE[gi*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign w_table[gi] = '0;
        end
    end

    assign w_entry     = w_table[r_idx];
    assign w_is_last   = (r_idx == c_LAST_IDX);
    assign w_ctrl_fire = ctrl_valid && w_ctrl_ready;
    assign ctrl_ready  = w_ctrl_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_ctrl_fire) begin
            if (w_is_last) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end
    end

    if (BUFFERED != 0) begin : g_buffered
        logic                  r_full;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_last;

        // Slot accepts a new token in the same cycle it drains
        assign w_ctrl_ready = !r_full || outs_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_full <= 1'b0;
                r_data <= '0;
                r_last <= 1'b0;
            end else if (w_ctrl_fire) begin
                r_full <= 1'b1;
                r_data <= w_entry;
                r_last <= w_is_last;
            end else if (r_full && outs_ready) begin
                r_full <= 1'b0;
            end
        end

        assign outs       = r_data;
        assign outs_valid = r_full;
        assign outs_last  = r_last;
    end else begin : g_passthrough
        assign w_ctrl_ready = outs_ready;
        assign outs         = w_entry;
        assign outs_valid   = ctrl_valid;
        assign outs_last    = w_is_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_constant_seq
// Purpose  : Self-checking bench for handshake_constant_seq, four configurations.
// Revision : 1.0
// ============================================================================
module tb_handshake_constant_seq;

    localparam int DW = 13;
    localparam logic [3*DW-1:0] TAB3 = {13'h1FFF, 13'h0001, 13'h0FAE};
    localparam logic [DW-1:0]   TAB1 = 13'h0FAE;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] tab [3];
    initial begin
        tab[0] = 13'h0FAE;
        tab[1] = 13'h0001;
        tab[2] = 13'h1FFF;
    end

    // a: N=3 buffered, b: N=3 pass-through, c: N=1 buffered, d: N=1 pass-through
    logic a_cv = 0, a_or = 0, b_cv = 0, b_or = 0, c_cv = 0, c_or = 0, d_cv = 0, d_or = 0;
    logic a_cr, a_ov, a_ol, b_cr, b_ov, b_ol, c_cr, c_ov, c_ol, d_cr, d_ov, d_ol;
    logic [DW-1:0] a_o, b_o, c_o, d_o;

    handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_CONSTS(3), .CONST_TABLE(TAB3), .BUFFERED(1)) u_a (
        .clk(clk), .rst(rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr), .outs(a_o),
        .outs_valid(a_ov), .outs_ready(a_or), .outs_last(a_ol));
    handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_CONSTS(3), .CONST_TABLE(TAB3), .BUFFERED(0)) u_b (
        .clk(clk), .rst(rst), .ctrl_valid(b_cv), .ctrl_ready(b_cr), .outs(b_o),
        .outs_valid(b_ov), .outs_ready(b_or), .outs_last(b_ol));
    handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_CONSTS(1), .CONST_TABLE(TAB1), .BUFFERED(1)) u_c (
        .clk(clk), .rst(rst), .ctrl_valid(c_cv), .ctrl_ready(c_cr), .outs(c_o),
        .outs_valid(c_ov), .outs_ready(c_or), .outs_last(c_ol));
    handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_CONSTS(1), .CONST_TABLE(TAB1), .BUFFERED(0)) u_d (
        .clk(clk), .rst(rst), .ctrl_valid(d_cv), .ctrl_ready(d_cr), .outs(d_o),
        .outs_valid(d_ov), .outs_ready(d_or), .outs_last(d_ol));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard model for the buffered N=3 instance
    exp_t aq[$];
    bit   am_full = 1'b0;
    int   am_idx  = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            bit fire_c;
            check("a_ctrl_ready", a_cr, (!am_full || a_or));
            check("a_outs_valid", a_ov, am_full);
            if (am_full) begin
                check("a_sb_depth", aq.size(), 1);
                if (aq.size() > 0) begin
                    check("a_outs", a_o, aq[0].data);
                    check("a_outs_last", a_ol, aq[0].last);
                    if (a_or && !rst) void'(aq.pop_front());
                end
            end
            if (rst) begin
                am_full = 1'b0;
                am_idx  = 0;
                aq.delete();
            end else begin
                fire_c = a_cv && (!am_full || a_or);
                if (am_full && a_or) am_full = 1'b0;
                if (fire_c) begin
                    aq.push_back('{data: tab[am_idx], last: (am_idx == 2)});
                    am_full = 1'b1;
                    am_idx  = (am_idx == 2) ? 0 : am_idx + 1;
                end
            end
        end
    end

    // Reference model for the pass-through N=3 instance
    int bm_idx = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("b_ctrl_ready", b_cr, b_or);
            check("b_outs_valid", b_ov, b_cv);
            if (b_cv) begin
                check("b_outs", b_o, tab[bm_idx]);
                check("b_outs_last", b_ol, (bm_idx == 2));
            end
            if (rst) bm_idx = 0;
            else if (b_cv && b_or) bm_idx = (bm_idx == 2) ? 0 : bm_idx + 1;
        end
    end

    // Single-entry instances: every transfer must carry entry 0 flagged last
    int c_cnt = 0;
    int d_cnt = 0;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (c_ov && c_or) begin
                check("c_outs", c_o, 13'h0FAE);
                check("c_outs_last", c_ol, 1);
                c_cnt++;
            end
            if (d_ov && d_or) begin
                check("d_outs", d_o, 13'h0FAE);
                check("d_outs_last", d_ol, 1);
                d_cnt++;
            end
        end
    end

    initial begin
        tick(2);
        mon_en = 1'b1;
        @(negedge clk);
        check("a_rst_outs", a_o, 0);
        check("a_rst_valid", a_ov, 0);
        check("a_rst_last", a_ol, 0);
        check("c_rst_valid", c_ov, 0);
        tick();
        rst = 1'b0;

        // Basic sequence with wrap, sustained throughput
        a_cv = 1; a_or = 1;
        tick(7);
        a_cv = 0;
        tick(2);

        // Backpressure
        rst = 1; tick(); rst = 0;
        a_cv = 1; a_or = 1; tick();
        a_or = 0; tick(4);
        a_or = 1; tick();
        a_cv = 0; tick(2);

        // Sparse tokens
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 4; k++) begin
            a_cv = 1; tick();
            a_cv = 0; tick(2);
        end

        // Reset while slot holds a token
        rst = 1; tick(); rst = 0;
        a_cv = 1; a_or = 1; tick(2);
        a_cv = 0; a_or = 0; rst = 1; tick();
        rst = 0;
        @(negedge clk);
        check("a_midrst_valid", a_ov, 0);
        check("a_midrst_outs", a_o, 0);
        tick();
        a_cv = 1; a_or = 1; tick();
        a_cv = 0; tick(2);
        check("a_sb_drained", aq.size(), 0);

        // Pass-through with toggled consumer readiness
        b_cv = 1;
        b_or = 1; tick();
        b_or = 0; tick();
        b_or = 1; tick(2);
        b_cv = 0; tick();

        // Single-entry tables, back-to-back tokens
        c_cv = 1; c_or = 1; d_cv = 1; d_or = 1;
        tick(3);
        c_cv = 0; d_cv = 0;
        tick(2);
        check("c_transfers", c_cnt, 3);
        check("d_transfers", d_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
